// File: rtl/award_spawn_controller.sv
// Award spawn controller: timed spawn at a random tile, pickup detection, per-player bonus timers.
// Optional AWARD_LIFETIME_EN: an uncollected award is withdrawn after LIFETIME_FRAMES frames.
module award_spawn_controller #(
    parameter int          SPAWN_DELAY_FRAMES = 180,
    parameter int          BONUS_FRAMES       = 300,
    parameter int          LIFETIME_FRAMES    = 600,
    parameter int          MAX_TILE_X         = 17,
    parameter int          MAX_TILE_Y         = 12,
    parameter logic [15:0] LFSR_SEED          = 16'hACE1
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       startOfFrame,
    input  logic       awardDR,
    input  logic       awardHidden,
    input  logic       tank1DR,
    input  logic       tank2DR,
    output logic       up,
    output logic [4:0] randomX,
    output logic [4:0] randomY,
    output logic       take1,
    output logic       take2,
    output logic       bonus1,
    output logic       bonus2
);

    localparam logic [15:0] SPAWN_LOAD = 16'(SPAWN_DELAY_FRAMES);
    localparam logic [15:0] BONUS_LOAD = 16'(BONUS_FRAMES);

    typedef enum logic [1:0] {
        S_WAIT,
        S_SPAWN,
        S_ARM,
        S_SHOWN
    } state_t;

    state_t      state;
    logic [15:0] frame_cnt;
    logic [15:0] lfsr;
    logic [15:0] lfsr_next;
    logic [15:0] bonus_cnt1;
    logic [15:0] bonus_cnt2;
    logic [4:0]  tile_x;
    logic [4:0]  tile_y;
    logic        hit1;
    logic        hit2;
    logic        expire;

    assign lfsr_next = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};

    // Scale a 5-bit random value into [0, MAX_TILE) by keeping the top half of the product.
    assign tile_x = 5'((10'(lfsr[4:0]) * 10'(MAX_TILE_X)) >> 5);
    assign tile_y = 5'((10'(lfsr[9:5]) * 10'(MAX_TILE_Y)) >> 5);

    assign hit1 = awardDR & tank1DR;
    assign hit2 = awardDR & tank2DR;

    assign bonus1 = (bonus_cnt1 != 16'd0);
    assign bonus2 = (bonus_cnt2 != 16'd0);

`ifdef AWARD_LIFETIME_EN
    localparam logic [15:0] LIFE_LOAD = 16'(LIFETIME_FRAMES);

    logic [15:0] life_cnt;

    // Expiry fires on the frame that would take the counter to zero.
    assign expire = (life_cnt == 16'd0)
                  || (startOfFrame && life_cnt == 16'd1);

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            life_cnt <= 16'd0;
        end else if (state == S_ARM && !awardHidden) begin
            life_cnt <= LIFE_LOAD;
        end else if (startOfFrame && life_cnt != 16'd0) begin
            life_cnt <= life_cnt - 16'd1;
        end
    end
`else
    assign expire = 1'b0;
`endif

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state      <= S_WAIT;
            frame_cnt  <= SPAWN_LOAD;
            lfsr       <= LFSR_SEED;
            bonus_cnt1 <= 16'd0;
            bonus_cnt2 <= 16'd0;
            up         <= 1'b0;
            take1      <= 1'b0;
            take2      <= 1'b0;
            randomX    <= 5'd0;
            randomY    <= 5'd0;
        end else begin
            lfsr  <= lfsr_next;
            up    <= 1'b0;
            take1 <= 1'b0;
            take2 <= 1'b0;

            if (startOfFrame && bonus_cnt1 != 16'd0) begin
                bonus_cnt1 <= bonus_cnt1 - 16'd1;
            end
            if (startOfFrame && bonus_cnt2 != 16'd0) begin
                bonus_cnt2 <= bonus_cnt2 - 16'd1;
            end

            unique case (state)
                S_WAIT: begin
                    if (startOfFrame) begin
                        if (frame_cnt <= 16'd1) begin
                            randomX <= tile_x;
                            randomY <= tile_y;
                            up      <= 1'b1;
                            state   <= S_SPAWN;
                        end else begin
                            frame_cnt <= frame_cnt - 16'd1;
                        end
                    end
                end
                S_SPAWN: begin
                    state <= S_ARM;
                end
                S_ARM: begin
                    if (!awardHidden) begin
                        state <= S_SHOWN;
                    end
                end
                S_SHOWN: begin
                    // Later loads override the decrements above; player 1 wins ties.
                    if (hit1) begin
                        take1      <= 1'b1;
                        bonus_cnt1 <= BONUS_LOAD;
                        frame_cnt  <= SPAWN_LOAD;
                        state      <= S_WAIT;
                    end else if (hit2) begin
                        take2      <= 1'b1;
                        bonus_cnt2 <= BONUS_LOAD;
                        frame_cnt  <= SPAWN_LOAD;
                        state      <= S_WAIT;
                    end else if (expire) begin
                        take1     <= 1'b1;
                        take2     <= 1'b1;
                        frame_cnt <= SPAWN_LOAD;
                        state     <= S_WAIT;
                    end
                end
                default: begin
                    state <= S_WAIT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_award_spawn_controller.sv
// Directed bench for award_spawn_controller (short delays, 5-frame bonus, 4-frame lifetime).
module tb_award_spawn_controller;

    logic       clk;
    logic       resetN;
    logic       startOfFrame;
    logic       awardDR;
    logic       awardHidden;
    logic       tank1DR;
    logic       tank2DR;
    logic       up;
    logic [4:0] randomX;
    logic [4:0] randomY;
    logic       take1;
    logic       take2;
    logic       bonus1;
    logic       bonus2;

    int passed = 0;
    int total  = 0;

    logic [15:0] m;
    logic [15:0] snap;
    logic        seen;

    award_spawn_controller #(
        .SPAWN_DELAY_FRAMES(3),
        .BONUS_FRAMES(5),
        .LIFETIME_FRAMES(4),
        .MAX_TILE_X(17),
        .MAX_TILE_Y(12),
        .LFSR_SEED(16'hACE1)
    ) dut (
        .clk(clk),
        .resetN(resetN),
        .startOfFrame(startOfFrame),
        .awardDR(awardDR),
        .awardHidden(awardHidden),
        .tank1DR(tank1DR),
        .tank2DR(tank2DR),
        .up(up),
        .randomX(randomX),
        .randomY(randomY),
        .take1(take1),
        .take2(take2),
        .bonus1(bonus1),
        .bonus2(bonus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference LFSR, free-running from reset like the generator it predicts.
    always @(posedge clk or negedge resetN) begin
        if (!resetN) m <= 16'hACE1;
        else         m <= {m[14:0], m[15] ^ m[13] ^ m[12] ^ m[10]};
    end

    function automatic logic [15:0] tile(input logic [4:0] v, input int n);
        return 16'((int'(v) * n) / 32);
    endfunction

    task automatic check(input string tag, input logic [15:0] obs,
                         input logic [15:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Idle cycle, then one frame pulse; returns just after the sampling edge.
    task automatic frame();
        tick();
        snap = m;
        startOfFrame = 1'b1;
        tick();
        startOfFrame = 1'b0;
    endtask

    task automatic show();
        awardHidden = 1'b0;
        tick();
        tick();
    endtask

    task automatic check_tile(input string tag);
        check({tag, "_x"}, 16'(randomX), tile(snap[4:0], 17));
        check({tag, "_y"}, 16'(randomY), tile(snap[9:5], 12));
    endtask

    initial begin
        resetN = 1'b0;
        startOfFrame = 1'b0;
        awardDR = 1'b0;
        awardHidden = 1'b1;
        tank1DR = 1'b0;
        tank2DR = 1'b0;
        seen = 1'b0;
        repeat (3) tick();
        check("rst_up", 16'(up), 16'd0);
        check("rst_take1", 16'(take1), 16'd0);
        check("rst_take2", 16'(take2), 16'd0);
        check("rst_x", 16'(randomX), 16'd0);
        check("rst_y", 16'(randomY), 16'd0);
        check("rst_bonus1", 16'(bonus1), 16'd0);
        check("rst_bonus2", 16'(bonus2), 16'd0);
        resetN = 1'b1;

        // First spawn after three frames
        frame(); check("spawn_f1_up", 16'(up), 16'd0);
        frame(); check("spawn_f2_up", 16'(up), 16'd0);
        frame(); check("spawn_f3_up", 16'(up), 16'd1);
        check_tile("spawn1");
        tick();  check("spawn_pulse_end", 16'(up), 16'd0);

        // Overlap during ARM must be ignored
        awardDR = 1'b1; tank1DR = 1'b1;
        tick();  check("arm_ignore", 16'(take1), 16'd0);
        awardDR = 1'b0; tank1DR = 1'b0;
        awardHidden = 1'b0;
        tick();

        // Player 1 collects
        awardDR = 1'b1; tank1DR = 1'b1;
        tick();
        check("p1_take1", 16'(take1), 16'd1);
        check("p1_take2", 16'(take2), 16'd0);
        check("p1_bonus1", 16'(bonus1), 16'd1);
        awardDR = 1'b0; tank1DR = 1'b0; awardHidden = 1'b1;
        tick();  check("p1_take1_end", 16'(take1), 16'd0);
        frame(); check("p1_b_f1", 16'(bonus1), 16'd1);
        check("p1_up_f1", 16'(up), 16'd0);
        frame(); check("p1_b_f2", 16'(bonus1), 16'd1);
        frame(); check("p1_b_f3", 16'(bonus1), 16'd1);
        check("p1_up_f3", 16'(up), 16'd1);
        check_tile("spawn2");
        frame(); check("p1_b_f4", 16'(bonus1), 16'd1);
        frame(); check("p1_b_f5", 16'(bonus1), 16'd0);

        // Three-way overlap: player 1 wins
        show();
        awardDR = 1'b1; tank1DR = 1'b1; tank2DR = 1'b1;
        tick();
        check("tie_take1", 16'(take1), 16'd1);
        check("tie_take2", 16'(take2), 16'd0);
        check("tie_bonus1", 16'(bonus1), 16'd1);
        check("tie_bonus2", 16'(bonus2), 16'd0);
        awardDR = 1'b0; tank1DR = 1'b0; tank2DR = 1'b0; awardHidden = 1'b1;
        tick();
        check("tie_take1_end", 16'(take1), 16'd0);
        check("tie_take2_end", 16'(take2), 16'd0);
        repeat (3) frame();
        check("tie_respawn", 16'(up), 16'd1);

        // Player 2 collects, then again with two bonus frames left
        show();
        awardDR = 1'b1; tank2DR = 1'b1;
        tick();
        check("p2_take2", 16'(take2), 16'd1);
        check("p2_take1", 16'(take1), 16'd0);
        check("p2_bonus2", 16'(bonus2), 16'd1);
        awardDR = 1'b0; tank2DR = 1'b0; awardHidden = 1'b1;
        tick();  check("p2_take2_end", 16'(take2), 16'd0);
        repeat (3) frame();
        check("p2_respawn", 16'(up), 16'd1);
        check("p2_bonus1_off", 16'(bonus1), 16'd0);
        check("p2_bonus2_left", 16'(bonus2), 16'd1);
        show();
        awardDR = 1'b1; tank2DR = 1'b1;
        tick();  check("p2_retake", 16'(take2), 16'd1);
        awardDR = 1'b0; tank2DR = 1'b0; awardHidden = 1'b1;
        repeat (4) frame();
        check("p2_reload_f4", 16'(bonus2), 16'd1);
        frame(); check("p2_reload_f5", 16'(bonus2), 16'd0);

        // Asynchronous reset while SHOWN with bonus1 active
        show();
        awardDR = 1'b1; tank1DR = 1'b1;
        tick();
        awardDR = 1'b0; tank1DR = 1'b0; awardHidden = 1'b1;
        repeat (3) frame();
        show();
        check("pre_rst_bonus1", 16'(bonus1), 16'd1);
        #2 resetN = 1'b0;
        #1;
        check("mid_rst_up", 16'(up), 16'd0);
        check("mid_rst_take1", 16'(take1), 16'd0);
        check("mid_rst_take2", 16'(take2), 16'd0);
        check("mid_rst_x", 16'(randomX), 16'd0);
        check("mid_rst_y", 16'(randomY), 16'd0);
        check("mid_rst_bonus1", 16'(bonus1), 16'd0);
        check("mid_rst_bonus2", 16'(bonus2), 16'd0);
        tick();
        resetN = 1'b1;
        frame(); check("post_rst_f1", 16'(up), 16'd0);
        frame(); check("post_rst_f2", 16'(up), 16'd0);
        frame(); check("post_rst_f3", 16'(up), 16'd1);
        check_tile("spawn3");

`ifdef AWARD_LIFETIME_EN
        // Uncollected award withdrawn after four frames
        show();
        frame(); check("life_f1", 16'(take1), 16'd0);
        frame(); check("life_f2", 16'(take1), 16'd0);
        frame(); check("life_f3", 16'(take2), 16'd0);
        frame();
        check("life_take1", 16'(take1), 16'd1);
        check("life_take2", 16'(take2), 16'd1);
        check("life_bonus1", 16'(bonus1), 16'd0);
        check("life_bonus2", 16'(bonus2), 16'd0);
        tick();
        check("life_end1", 16'(take1), 16'd0);
        check("life_end2", 16'(take2), 16'd0);
`else
        // Without lifetime the award stays until collected
        show();
        for (int i = 0; i < 6; i++) begin
            frame();
            seen = seen | take1 | take2;
        end
        check("no_expiry", 16'(seen), 16'd0);
        awardDR = 1'b1; tank2DR = 1'b1;
        tick();  check("late_take2", 16'(take2), 16'd1);
        awardDR = 1'b0; tank2DR = 1'b0;
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/award_spawn_controller.md
Name: award_spawn_controller

Overview:
- Drives the award square's spawn side and consumes its drawing request.
- Generates the `up` pulse and the random tile position (`randomX` / `randomY`).
- Detects tank/award pixel overlap and issues one-cycle `take1` / `take2` pulses.
- Grants a frame-timed bonus flag to the collecting player. Sits in the game-logic layer between the VGA objects and the tank controllers.

Parameters:
- SPAWN_DELAY_FRAMES, 180, frames between reset/collection and the next spawn (>=1).
- BONUS_FRAMES, 300, frames a bonus flag stays high after collection (>=1).
- LIFETIME_FRAMES, 600, frames an uncollected award stays visible (optional feature only).
- MAX_TILE_X, 17, number of legal X tiles (1..32); `randomX` is always < MAX_TILE_X.
- MAX_TILE_Y, 12, number of legal Y tiles (1..32); `randomY` is always < MAX_TILE_Y.
- LFSR_SEED, 16'hACE1, nonzero LFSR reset value.

Ports:
- clk  in  1  system clock.
- resetN  in  1  asynchronous active-low reset.
- startOfFrame  in  1  one-cycle pulse per VGA frame.
- awardDR  in  1  award object drawing request.
- awardHidden  in  1  award object `ena` (1 = hidden).
- tank1DR  in  1  player-1 tank drawing request.
- tank2DR  in  1  player-2 tank drawing request.
- up  out  1  one-cycle spawn pulse to the award object.
- randomX  out  5  award tile X (award pixel X = randomX*32).
- randomY  out  5  award tile Y.
- take1  out  1  one-cycle collect pulse, player 1.
- take2  out  1  one-cycle collect pulse, player 2.
- bonus1  out  1  player-1 bonus active.
- bonus2  out  1  player-2 bonus active.

Behaviour:
- Reset (async, resetN=0): up=0, take1=0, take2=0, randomX=0, randomY=0, bonus1=0, bonus2=0. State=WAIT, frameCnt=SPAWN_DELAY_FRAMES, lfsr=LFSR_SEED, bonus counters=0.
- LFSR: 16-bit Fibonacci, advances every clock. lfsr <= {lfsr[14:0], lfsr[15]^lfsr[13]^lfsr[12]^lfsr[10]}.
- Tile mapping: 10-bit product, upper 5 bits taken.
  - X = (lfsr[4:0]*MAX_TILE_X)>>5.
  - Y = (lfsr[9:5]*MAX_TILE_Y)>>5.
- State WAIT:
  - On each startOfFrame, frameCnt decrements.
  - When frameCnt==1 and startOfFrame: latch randomX/randomY from the current lfsr, go to SPAWN.
- State SPAWN: up=1 for exactly this one cycle, then go to ARM.
- State ARM:
  - Wait for awardHidden==0, then go to SHOWN.
  - Collision inputs are ignored in ARM.
- State SHOWN:
  - Evaluated every clock; hit1 = awardDR&tank1DR, hit2 = awardDR&tank2DR.
  - hit1 (including simultaneous hit1&hit2): take1=1 one cycle, bonus1 counter loads BONUS_FRAMES, go to WAIT.
  - hit2 only: take2=1 one cycle, bonus2 counter loads BONUS_FRAMES, go to WAIT.
  - Tie rule: player 1 wins; take1 and take2 are never high together from collection.
- WAIT entry after collection: frameCnt reloads SPAWN_DELAY_FRAMES.
- randomX/randomY hold their latched values from SPAWN until the next SPAWN.
- Bonus counters:
  - Each counter decrements on startOfFrame while nonzero.
  - bonusN = (counterN != 0).
  - Collection while a bonus is active reloads the counter to BONUS_FRAMES (no accumulation).
  - Load and decrement in the same cycle: load wins.
- Reset mid-operation (any state): immediate return to reset values, including dropping active bonuses.
- up and take pulses are registered outputs. take is asserted the cycle after the overlapping pixel is sampled.

Optional Feature:
- Macro AWARD_LIFETIME_EN.
- Defined:
  - A lifeCnt loads LIFETIME_FRAMES on entry to SHOWN and decrements on startOfFrame.
  - When lifeCnt reaches 0 with no hit: take1=1 and take2=1 together for one cycle (hides the award), no bonus loaded, go to WAIT with SPAWN_DELAY_FRAMES.
  - A hit in the same cycle as expiry counts as a hit (normal collection rule).
- Undefined: the award stays in SHOWN until collected; LIFETIME_FRAMES is unused.

Test Plan:
- SPAWN_DELAY_FRAMES=3, reset released, three startOfFrame pulses -> up=1 for exactly one cycle after the 3rd pulse; randomX<17, randomY<12, matching the LFSR model.
- In SHOWN, awardDR=1 and tank1DR=1 for one cycle -> take1=1 next cycle only; bonus1=1 for exactly BONUS_FRAMES=5 startOfFrame pulses, then 0; next up follows 3 frames later.
- awardDR, tank1DR and tank2DR high together -> take1 pulses, take2 stays 0, only bonus1 set.
- Player 2 collects, then collects again with 2 bonus frames left -> bonus2 stays 1 for 5 more frames after the second take2.
- resetN pulsed low while in SHOWN with bonus1=1 -> all outputs 0 immediately; next up after SPAWN_DELAY_FRAMES frames.
- AWARD_LIFETIME_EN defined, LIFETIME_FRAMES=4, no tank overlap -> after the 4th frame in SHOWN, take1=take2=1 in the same single cycle, bonus1=bonus2=0.
